transceiver_tmo: RTL
====================

Name: transceiver_tmo

Overview:
- Output-side flit sender of a PGNoC switch; successor to the single-mode switch transmitter.
- Pops flits from the switch input queue and forwards each packet wormhole-style to one of PORTS_NUM+1 output ports (port PORTS_NUM = local), using the wr_ready/r_ready 4-phase handshake.
- New over the previous generation: explicit port-connected mask instead of 'z detection, selectable drop-or-loopback for unroutable packets, per-handshake timeout with packet drain, and saturating sent/dropped packet counters.

Parameters:
- DATA_SIZE, 32, payload bits per flit
- ADDR_SIZE, 4, destination-address bits
- PORTS_NUM, 4, network ports; local port index = PORTS_NUM
- TIMEOUT, 64, cycles allowed per handshake phase; 0 disables timeout
- DROP_UNROUTABLE, 0, 1 = drop packets to unconnected/invalid ports; 0 = loop back to local port
- CNT_W, 16, statistics counter width
- localparam BUS_SIZE = DATA_SIZE+ADDR_SIZE+1; PORT_W = $clog2(PORTS_NUM+1)

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- mem_empty  in  1  input queue empty
- data_i  in  BUS_SIZE  head-of-queue flit; [ADDR_SIZE-1:0] dest, [ADDR_SIZE] tail flag
- route_port  in  PORT_W  output port for data_i dest (from external routing_module)
- port_connected  in  PORTS_NUM+1  1 = port has a neighbour
- r_ready_in  in  PORTS_NUM+1  receiver ack per port
- mem_readed  out  1  one-cycle pop strobe to queue
- wr_ready_out  out  PORTS_NUM+1  flit-valid per port
- data_o  out  BUS_SIZE*(PORTS_NUM+1)  per-port flit slices
- busy  out  1  state != IDLE
- drop_pulse  out  1  one cycle on packet drop
- sent_pkts  out  CNT_W  packets fully delivered, saturating
- dropped_pkts  out  CNT_W  packets dropped, saturating

Behaviour:
- All outputs registered. Reset (async, a_rst_n=0): state IDLE; wr_ready_out, data_o, mem_readed, drop_pulse, counters, timer = 0; port_r = PORTS_NUM. Assertion mid-packet aborts immediately, nothing is popped.
- mem_readed and drop_pulse default to 0 every cycle.
- IDLE: if !mem_empty, latch port_r:
  - route_port <= PORTS_NUM and port_connected[route_port]=1: port_r = route_port, go SEND.
  - Otherwise, DROP_UNROUTABLE=0: port_r = PORTS_NUM, go SEND.
  - Otherwise, DROP_UNROUTABLE=1: go DROP.
  - Timer cleared on every transition.
- SEND:
  - If mem_empty: wr_ready_out[port_r] = 0, timer held.
  - Else if r_ready_in[port_r]=0: data_o slice[port_r] = data_i, wr_ready_out[port_r] = 1, mem_readed = 1, tail_r = data_i[ADDR_SIZE], timer = 0, go ACCEPT.
  - Else timer++. Timer reaching TIMEOUT-1 (TIMEOUT>0) goes to DROP.
- ACCEPT:
  - If r_ready_in[port_r]=1: wr_ready_out[port_r] = 0. If tail_r: sent_pkts++, go IDLE; else go SEND.
  - Else timer++. On timeout: wr_ready_out[port_r] = 0. If tail_r: count drop, go IDLE; else go DROP.
- DROP (drain remainder of packet):
  - Alternating pop/wait cycles prevent double-pop, since mem_readed is registered.
  - In a pop cycle with !mem_empty: mem_readed = 1. If data_i tail: count drop, go IDLE.
  - No output handshake in this state.
- Count drop = dropped_pkts++ (saturating) plus drop_pulse = 1.
- Non-selected data_o slices hold their value; only port_r's wr_ready bit may be 1.
- Latency: flit visible on data_o one cycle after the SEND edge that samples r_ready_in=0. Minimum 3 cycles per flit (SEND, ACCEPT, SEND).
- Counters saturate at all-ones.

Decomposition:
- Shared package pgnoc_pkg: BUS_SIZE/flit field offsets (DEST_LSB=0, TAIL_BIT=ADDR_SIZE), state encoding (IDLE, SEND, ACCEPT, DROP), port-width function.
- One sub-module: tmo_counter (load/clear/increment, terminal-count flag). Statistics counters are inline.

Test Plan:
Setup for all scenarios: PORTS_NUM=4, DATA_SIZE=32, ADDR_SIZE=4, TIMEOUT=8.
- Single-flit packet: route_port=2, connected=5'b11111, data_i tail=1, receiver acks after 2 cycles -> mem_readed pulses once; data_o[2*37+:37]=data_i; wr_ready_out=5'b00100 until ack; sent_pkts=1; back to IDLE.
- 3-flit packet to port 1, queue empties between flit 2 and 3 -> wr_ready_out[1]=0 while empty; port_r stays 1 for flit 3 despite a new route_port; sent_pkts=1.
- Unconnected port: connected=5'b11011, route_port=2, DROP_UNROUTABLE=0 -> delivered on port 4. Same with DROP_UNROUTABLE=1 -> 2-flit packet drained, 2 pops, drop_pulse once, dropped_pkts=1, no wr_ready_out.
- Receiver stuck at r_ready_in=1 on port 3 -> after 8 cycles in SEND, DROP; remaining flits drained to tail; dropped_pkts=1.
- Ack never arrives on head flit of 4-flit packet -> wr_ready_out[3] falls after 8 cycles; 3 further pops; drop_pulse once.
- a_rst_n low during ACCEPT -> all outputs 0 immediately; after release, next packet sent normally. Additionally force sent_pkts=16'hFFFF -> stays 16'hFFFF after one more delivery.

Source files
------------

// File: rtl/pgnoc_pkg.sv
// Shared PGNoC definitions: flit field layout, transmitter state encoding and
// width helpers used by the switch transmitter and its bench.
package pgnoc_pkg;

  localparam int DEST_LSB = 0;

  typedef enum logic [1:0] {IDLE, SEND, ACCEPT, DROP} tx_state_e;

  function automatic int port_width(input int ports);
    return $clog2(ports + 1);
  endfunction

  function automatic int bus_size(input int data_size, input int addr_size);
    return data_size + addr_size + 1;
  endfunction

  function automatic int tail_bit(input int addr_size);
    return addr_size;
  endfunction

endpackage

// File: rtl/tmo_counter.sv
// Handshake-phase timer: clear/load/increment with a terminal-count flag at
// TERM-1. TERM=0 disables the flag entirely.
module tmo_counter #(
  parameter int W    = 7,
  parameter int TERM = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         tc
);
  localparam logic [W-1:0] LAST = (TERM > 0) ? W'(TERM - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + W'(1);
  end

  assign tc = (TERM > 0) && (cnt == LAST);

endmodule

// File: rtl/transceiver_tmo.sv
// PGNoC switch output sender: forwards queued packets wormhole-style over a
// 4-phase wr_ready/r_ready handshake, with timeout drain and packet statistics.
module transceiver_tmo
  import pgnoc_pkg::*;
#(
  parameter  int DATA_SIZE       = 32,
  parameter  int ADDR_SIZE       = 4,
  parameter  int PORTS_NUM       = 4,
  parameter  int TIMEOUT         = 64,
  parameter  int DROP_UNROUTABLE = 0,
  parameter  int CNT_W           = 16,
  localparam int BUS_SIZE        = bus_size(DATA_SIZE, ADDR_SIZE),
  localparam int PORT_W          = port_width(PORTS_NUM)
) (
  input  logic                              clk,
  input  logic                              a_rst_n,
  input  logic                              mem_empty,
  input  logic [BUS_SIZE-1:0]               data_i,
  input  logic [PORT_W-1:0]                 route_port,
  input  logic [PORTS_NUM:0]                port_connected,
  input  logic [PORTS_NUM:0]                r_ready_in,
  output logic                              mem_readed,
  output logic [PORTS_NUM:0]                wr_ready_out,
  output logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_o,
  output logic                              busy,
  output logic                              drop_pulse,
  output logic [CNT_W-1:0]                  sent_pkts,
  output logic [CNT_W-1:0]                  dropped_pkts
);
  localparam int                TAIL_BIT = tail_bit(ADDR_SIZE);
  localparam int                TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PORT_W-1:0] LOCAL    = PORT_W'(PORTS_NUM);

  tx_state_e                          state, state_nx;
  logic [PORT_W-1:0]                  port_r, port_nx;
  logic                               tail_r, tail_nx, pop_ph, pop_ph_nx;
  logic [PORTS_NUM:0]                 wr_nx;
  logic [PORTS_NUM:0][BUS_SIZE-1:0]   data_q, data_nx;
  logic                               rd_nx, sent_inc, drop_inc;
  logic                               tmr_clr, tmr_inc, tmr_tc;
  logic                               routable;

  assign routable = (route_port <= LOCAL) && port_connected[route_port];

  tmo_counter #(.W(TMR_W), .TERM(TIMEOUT)) u_tmr (
    .clk      (clk),
    .rst_n    (a_rst_n),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tmr_inc),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nx  = state;
    port_nx   = port_r;
    tail_nx   = tail_r;
    pop_ph_nx = pop_ph;
    wr_nx     = wr_ready_out;
    data_nx   = data_q;
    rd_nx     = 1'b0;
    sent_inc  = 1'b0;
    drop_inc  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      IDLE: begin
        // A pop issued on the previous edge has not reached the queue yet, so
        // data_i/mem_empty are stale for one cycle after a drain.
        if (!mem_empty && !mem_readed) begin
          tmr_clr   = 1'b1;
          pop_ph_nx = 1'b1;
          if (routable) begin
            port_nx  = route_port;
            state_nx = SEND;
          end else if (DROP_UNROUTABLE == 0) begin
            port_nx  = LOCAL;
            state_nx = SEND;
          end else begin
            state_nx = DROP;
          end
        end
      end
      SEND: begin
        if (mem_empty) begin
          wr_nx[port_r] = 1'b0;
        end else if (!r_ready_in[port_r]) begin
          data_nx[port_r] = data_i;
          wr_nx[port_r]   = 1'b1;
          rd_nx           = 1'b1;
          tail_nx         = data_i[TAIL_BIT];
          tmr_clr         = 1'b1;
          state_nx        = ACCEPT;
        end else if (tmr_tc) begin
          tmr_clr   = 1'b1;
          pop_ph_nx = 1'b1;
          state_nx  = DROP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ACCEPT: begin
        if (r_ready_in[port_r]) begin
          wr_nx[port_r] = 1'b0;
          tmr_clr       = 1'b1;
          if (tail_r) begin
            sent_inc = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = SEND;
          end
        end else if (tmr_tc) begin
          wr_nx[port_r] = 1'b0;
          tmr_clr       = 1'b1;
          pop_ph_nx     = 1'b1;
          if (tail_r) begin
            drop_inc = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = DROP;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DROP: begin
        // Every pop is followed by a wait cycle so the registered pop strobe
        // has retired before data_i is inspected again.
        if (!pop_ph) begin
          pop_ph_nx = 1'b1;
        end else if (!mem_empty) begin
          rd_nx     = 1'b1;
          pop_ph_nx = 1'b0;
          if (data_i[TAIL_BIT]) begin
            drop_inc = 1'b1;
            tmr_clr  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state        <= IDLE;
      port_r       <= LOCAL;
      tail_r       <= 1'b0;
      pop_ph       <= 1'b0;
      wr_ready_out <= '0;
      data_q       <= '0;
      mem_readed   <= 1'b0;
      drop_pulse   <= 1'b0;
      sent_pkts    <= '0;
      dropped_pkts <= '0;
    end else begin
      state        <= state_nx;
      port_r       <= port_nx;
      tail_r       <= tail_nx;
      pop_ph       <= pop_ph_nx;
      wr_ready_out <= wr_nx;
      data_q       <= data_nx;
      mem_readed   <= rd_nx;
      drop_pulse   <= drop_inc;
      if (sent_inc && (sent_pkts != '1))    sent_pkts    <= sent_pkts + CNT_W'(1);
      if (drop_inc && (dropped_pkts != '1)) dropped_pkts <= dropped_pkts + CNT_W'(1);
    end
  end

  assign data_o = data_q;
  assign busy   = (state != IDLE);

endmodule
